// File: rtl/npc_pkg.sv
// Shared definitions for the fetch PC generator: BTB counter encoding and
// default reset / exception vectors.
package npc_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam logic [31:0] NPC_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] NPC_EXC_VECTOR = 32'h0000_4180;

    // Saturating 2-bit step toward the observed outcome.
    function automatic ctr_t ctr_step(input ctr_t c, input logic taken);
        ctr_t r;
        r = c;
        if (taken && c != ST)
            r = ctr_t'(c + 2'd1);
        else if (!taken && c != SNT)
            r = ctr_t'(c - 2'd1);
        return r;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bus of the PC generator: control inputs, BTB training and
// the current fetch PC with its prediction.
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            exc_valid;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic [XLEN-1:0] upd_target;
    logic            upd_taken;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    modport master (
        output stall, exc_valid, redirect_valid, redirect_pc,
               upd_valid, upd_pc, upd_target, upd_taken,
        input  pc, pred_taken, pred_target
    );

    modport slave (
        input  stall, exc_valid, redirect_valid, redirect_pc,
               upd_valid, upd_pc, upd_target, upd_taken,
        output pc, pred_taken, pred_target
    );
endinterface

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters:
// combinational lookup, single update port written on the rising edge.
module pc_btb
    import npc_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BTB_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken
);
    localparam int IW = $clog2(BTB_DEPTH);
    localparam int TW = XLEN - IW - 2;

    logic [BTB_DEPTH-1:0] valid;
    logic [TW-1:0]        tag    [BTB_DEPTH];
    logic [XLEN-1:0]      target [BTB_DEPTH];
    ctr_t                 ctr    [BTB_DEPTH];

    logic [IW-1:0] r_idx, u_idx;
    logic [TW-1:0] r_tag, u_tag;
    logic          u_hit;

    assign r_idx = lookup_pc[IW+1:2];
    assign r_tag = lookup_pc[XLEN-1:IW+2];
    assign u_idx = upd_pc[IW+1:2];
    assign u_tag = upd_pc[XLEN-1:IW+2];
    assign u_hit = valid[u_idx] && (tag[u_idx] == u_tag);

    assign pred_taken  = valid[r_idx] && (tag[r_idx] == r_tag) && ctr[r_idx][1];
    assign pred_target = target[r_idx];

    // Lookup sees the pre-update contents; the write lands on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                valid[i]  <= 1'b0;
                tag[i]    <= '0;
                target[i] <= '0;
                ctr[i]    <= WNT;
            end
        end else if (upd_valid) begin
            if (u_hit) begin
                ctr[u_idx] <= ctr_step(ctr[u_idx], upd_taken);
                if (upd_taken)
                    target[u_idx] <= upd_target;
            end else if (upd_taken) begin
                valid[u_idx]  <= 1'b1;
                tag[u_idx]    <= u_tag;
                target[u_idx] <= upd_target;
                ctr[u_idx]    <= WT;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register and next-PC priority mux; prediction comes from pc_btb.
module pc_gen
    import npc_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              BTB_DEPTH  = 8,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(NPC_RESET_PC),
    parameter logic [XLEN-1:0] EXC_VECTOR = XLEN'(NPC_EXC_VECTOR)
) (
    input logic     clk,
    input logic     rst_n,
    pc_gen_if.slave bus
);
    logic [XLEN-1:0] pc_q, pc_nxt;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;

    pc_btb #(
        .XLEN      (XLEN),
        .BTB_DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_pc   (pc_q),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (bus.upd_valid),
        .upd_pc      (bus.upd_pc),
        .upd_target  (bus.upd_target),
        .upd_taken   (bus.upd_taken)
    );

    // Exception and redirect win over stall; the word alignment is applied last
    // so no source can leave the PC misaligned.
    always_comb begin
        pc_nxt = pc_q + XLEN'(4);
        if (bus.exc_valid)
            pc_nxt = EXC_VECTOR;
        else if (bus.redirect_valid)
            pc_nxt = bus.redirect_pc;
        else if (bus.stall)
            pc_nxt = pc_q;
        else if (pred_taken)
            pc_nxt = pred_target;
        pc_nxt[1:0] = 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_nxt;
    end

    assign bus.pc          = pc_q;
    assign bus.pred_taken  = pred_taken;
    assign bus.pred_target = pred_target;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed scenarios plus random traffic,
// checked against an array-based reference of the fetch/BTB rules.
module tb_pc_gen;
    localparam int DEPTH = 8;
    localparam int IW    = 3;
    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC = 32'h0000_4180;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(32)) bus ();

    pc_gen #(.XLEN(32), .BTB_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        bit          tk;
        logic [31:0] tgt;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: one slot per BTB index, counter as an integer 0..3.
    logic [31:0] m_pc;
    bit          m_valid [DEPTH];
    logic [31:0] m_tag   [DEPTH];
    logic [31:0] m_tgt   [DEPTH];
    int          m_ctr   [DEPTH];

    function automatic void model_reset();
        m_pc = RST_PC;
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
    endfunction

    function automatic void lookup(input logic [31:0] a, output bit tk, output logic [31:0] tg);
        int idx;
        idx = int'((a >> 2) % DEPTH);
        tk  = m_valid[idx] && (m_tag[idx] == (a >> (2 + IW))) && (m_ctr[idx] >= 2);
        tg  = m_tgt[idx];
    endfunction

    function automatic void model_advance(input bit st, exc, rv, input logic [31:0] rpc,
                                          input bit uv, input logic [31:0] upc, utgt, input bit ut);
        bit          tk;
        logic [31:0] tg, n;
        int          idx;
        lookup(m_pc, tk, tg);
        if (exc)     n = EXC_PC;
        else if (rv) n = rpc;
        else if (st) n = m_pc;
        else if (tk) n = tg;
        else         n = m_pc + 32'd4;
        n = n & 32'hFFFF_FFFC;
        if (uv) begin
            idx = int'((upc >> 2) % DEPTH);
            if (m_valid[idx] && m_tag[idx] == (upc >> (2 + IW))) begin
                m_ctr[idx] = ut ? ((m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1)
                                : ((m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1);
                if (ut) m_tgt[idx] = utgt;
            end else if (ut) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = upc >> (2 + IW);
                m_tgt[idx]   = utgt;
                m_ctr[idx]   = 2;
            end
        end
        m_pc = n;
    endfunction

    // One cycle: drive inputs after the edge, queue the expected outputs,
    // then advance the reference on the next rising edge.
    task automatic step(input string nm, input bit st, exc, rv, input logic [31:0] rpc,
                        input bit uv, input logic [31:0] upc, utgt, input bit ut, input bit rn);
        exp_t        e;
        bit          tk;
        logic [31:0] tg;
        bus.stall          = st;
        bus.exc_valid      = exc;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.upd_valid      = uv;
        bus.upd_pc         = upc;
        bus.upd_target     = utgt;
        bus.upd_taken      = ut;
        rst_n              = rn;
        if (!rn) model_reset();
        lookup(m_pc, tk, tg);
        e.pc = m_pc; e.tk = tk; e.tgt = tg; e.tag = nm;
        exp_q.push_back(e);
        @(negedge clk);
        @(posedge clk);
        if (rn) model_advance(st, exc, rv, rpc, uv, upc, utgt, ut);
        #1;
    endtask

    task automatic idle(input string nm, input int n);
        for (int i = 0; i < n; i++) step(nm, 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 1);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (bus.pc !== e.pc) begin
                n_fail++;
                $display("FAIL %s pc: got %h want %h", e.tag, bus.pc, e.pc);
            end
            n_checks++;
            if (bus.pred_taken !== e.tk) begin
                n_fail++;
                $display("FAIL %s pred_taken: got %b want %b", e.tag, bus.pred_taken, e.tk);
            end
            if (e.tk) begin
                n_checks++;
                if (bus.pred_target !== e.tgt) begin
                    n_fail++;
                    $display("FAIL %s pred_target: got %h want %h", e.tag, bus.pred_target, e.tgt);
                end
            end
        end
    end

    function automatic logic [31:0] rnd_addr();
        logic [31:0] base;
        case ($urandom_range(0, 2))
            0:       base = 32'h0000_3000;
            1:       base = 32'h0000_3100;
            default: base = 32'h0000_7000;
        endcase
        return base + 32'(4 * $urandom_range(0, 31));
    endfunction

    initial begin
        model_reset();
        step("reset", 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
        step("reset", 0, 0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0);
        idle("seq", 3);

        // Allocate 0x3010 -> 0x3100 while fetching 0x300C; 0x3010 then predicts.
        step("alloc", 0, 0, 0, 32'h0, 1, 32'h3010, 32'h3100, 1, 1);
        idle("pred", 3);

        // Two not-taken trainings drop the counter to strong NT.
        step("nt1", 0, 0, 1, 32'h3000, 1, 32'h3010, 32'h0, 0, 1);
        step("nt2", 0, 0, 0, 32'h0, 1, 32'h3010, 32'h0, 0, 1);
        idle("nt_seq", 5);

        step("stall_redir", 1, 0, 1, 32'h3203, 0, 32'h0, 32'h0, 0, 1);
        step("stall_exc", 1, 1, 1, 32'h3203, 0, 32'h0, 32'h0, 0, 1);
        idle("exc", 1);

        // Same index, different tag: 0x3030 replaces 0x3010.
        step("alias1", 0, 0, 0, 32'h0, 1, 32'h3010, 32'h3100, 1, 1);
        step("alias2", 0, 0, 0, 32'h0, 1, 32'h3030, 32'h3200, 1, 1);
        step("alias_r1", 0, 0, 1, 32'h3010, 0, 32'h0, 32'h0, 0, 1);
        step("alias_r2", 0, 0, 1, 32'h3030, 0, 32'h0, 32'h0, 0, 1);
        idle("alias", 3);

        step("wrap", 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0, 1);
        idle("wrap", 2);
        // Reset while an allocation is pending: it must be lost.
        step("mid_rst", 0, 0, 0, 32'h0, 1, 32'h3000, 32'h3100, 1, 0);
        idle("post_rst", 3);

        for (int i = 0; i < 2000; i++) begin
            bit          st, exc, rv, uv, ut, rn;
            logic [31:0] rpc, upc, utgt;
            st   = ($urandom_range(0, 3) == 0);
            exc  = ($urandom_range(0, 31) == 0);
            rv   = ($urandom_range(0, 7) == 0);
            rpc  = rnd_addr() | 32'($urandom_range(0, 3));
            uv   = ($urandom_range(0, 1) == 0);
            upc  = rnd_addr();
            utgt = rnd_addr();
            ut   = ($urandom_range(0, 2) != 0);
            rn   = ($urandom_range(0, 199) != 0);
            step("rand", st, exc, rv, rpc, uv, upc, utgt, ut, rn);
        end

        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC/address width.
REQ-002 SHALL have parameter BTB_DEPTH, default 8, meaning BTB entry count; power of two, ≥2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning PC after reset.
REQ-004 SHALL have parameter EXC_VECTOR, default 32'h0000_4180, meaning exception entry PC.
REQ-005 SHALL have port clk  in  1  meaning the single clock; all state on rising edge.
REQ-006 SHALL have port rst_n  in  1  meaning asynchronous, active-low reset.
REQ-007 SHALL have port stall  in  1  meaning hold PC.
REQ-008 SHALL have port exc_valid  in  1  meaning take exception.
REQ-009 SHALL have port redirect_valid  in  1  meaning EX-stage resolved PC differs from fetched path.
REQ-010 SHALL have port redirect_pc  in  XLEN  meaning corrected PC (branch/jump/jr/jalr).
REQ-011 SHALL have port upd_valid  in  1  meaning train BTB with a resolved control-transfer instruction.
REQ-012 SHALL have port upd_pc  in  XLEN  meaning address of that instruction.
REQ-013 SHALL have port upd_target  in  XLEN  meaning its taken target.
REQ-014 SHALL have port upd_taken  in  1  meaning its actual outcome.
REQ-015 SHALL have port pc  out  XLEN  meaning current fetch PC (registered).
REQ-016 SHALL have port pred_taken  out  1  meaning current fetch predicted taken.
REQ-017 SHALL have port pred_target  out  XLEN  meaning predicted target (valid when pred_taken).

Function
REQ-018 SHALL compute next PC by priority: exc_valid -> EXC_VECTOR; redirect_valid -> redirect_pc; stall -> pc; pred_taken -> pred_target; else pc+4.
REQ-019 SHALL load next PC into pc every cycle; redirect and exception override stall.
REQ-020 SHALL force pc[1:0] to 2'b00 whatever the source; redirect_pc[1:0] is ignored.
REQ-021 SHALL compute pc+4 modulo 2^XLEN (wrap from all-ones word to 0, no flag).
REQ-022 SHALL index BTB with pc[log2(BTB_DEPTH)+1:2]; tag = pc[XLEN-1:log2(BTB_DEPTH)+2].
REQ-023 SHALL hold per entry: valid, tag, target, 2-bit saturating counter (00 strong NT, 01 weak NT, 10 weak T, 11 strong T).
REQ-024 SHALL read BTB combinationally: pred_taken = valid & tag match & counter[1]; pred_target = entry target.
REQ-025 SHALL, on upd_valid with tag hit, increment (taken) or decrement (not taken) counter saturating at 11/00, and rewrite target when taken.
REQ-026 SHALL, on upd_valid with miss and upd_taken=1, allocate (replace) entry: valid=1, tag, target, counter=10.
REQ-027 SHALL NOT allocate on miss with upd_taken=0.
REQ-028 SHALL make BTB writes visible next cycle; same-cycle lookup of the written index returns old contents.
REQ-029 SHALL train BTB regardless of stall, redirect or exc_valid.

Reset
REQ-030 SHALL, while rst_n=0, set pc=RESET_PC, clear every valid bit, set every counter to 01.
REQ-031 SHALL therefore output pred_taken=0 and pred_target=BTB entry target (don't-care) during and right after reset.
REQ-032 SHALL, on reset assertion mid-operation, abandon any pending update; first post-reset fetch is RESET_PC.

Structure
REQ-033 SHALL take counter encodings (SNT/WNT/WT/ST) and default RESET_PC/EXC_VECTOR from shared package npc_pkg.
REQ-034 SHALL place BTB storage, lookup and update in sub-module pc_btb (parameters XLEN, BTB_DEPTH); pc_gen holds the PC register and priority mux.

Verification
REQ-035 SHALL check: release reset, no inputs -> pc sequence 0x3000, 0x3004, 0x3008; pred_taken=0.
REQ-036 SHALL check: upd_valid, upd_pc=0x3010, upd_target=0x3100, upd_taken=1; fetch 0x3010 -> pred_taken=1, next pc=0x3100.
REQ-037 SHALL check: two not-taken updates for 0x3010 after REQ-036 -> counter 00, fetch 0x3010 -> next pc 0x3014.
REQ-038 SHALL check: stall=1, redirect_valid=1, redirect_pc=0x3203 same cycle -> pc=0x3200; adding exc_valid=1 -> pc=0x4180.
REQ-039 SHALL check: upd_pc=0x3010 then upd_pc=0x3030 (same index, different tag, taken) -> 0x3010 misses, 0x3030 predicts.
REQ-040 SHALL check: XLEN=32, redirect_pc=0xFFFF_FFFC, no prediction -> next pc 0x0000_0000; assert rst_n mid-run -> pc=0x3000 immediately.
